modred_serial: RTL
==================

Name: modred_serial

Overview:
- Sequential modular reducer on the consumer side of the multiplier's product interface.
- Accepts a 2N-bit product P with an N-bit modulus M and returns R = P mod M.
- Uses radix-2^K interleaved shift/conditional-subtract over the low half of P.
- Sits directly after fastKaratsuba, taking its P/out_valid output, to complete the modular multiplication path.

Parameters:
- N, 256, operand/modulus width; product width is 2N.
- K, 1, bits retired per cycle; legal values 1, 2, 4, 8; N mod K == 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  P and M valid this cycle.
- in_ready  out  1  block can accept; equals (state==IDLE).
- P  in  2N  product to reduce.
- M  in  N  modulus.
- R  out  N  reduced result; holds its value until the next result.
- out_valid  out  1  one-cycle pulse; R and err are valid.
- err  out  1  precondition violated; sampled with out_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, R=0, err=0, out_valid=0, internal registers cleared.
  - in_ready=1 during reset; in_valid is ignored while reset is low.
- States and transitions:
  - IDLE -> RUN on accept.
  - IDLE -> DONE on accept with a precondition error.
  - RUN -> DONE when the iteration count expires.
  - DONE -> IDLE unconditionally.
- Accept: rising edge with in_valid & in_ready. At that edge latch:
  - acc = {1'b0, P[2N-1:N]} (N+1 bits)
  - lo = P[N-1:0] (shift register)
  - mod = M
  - cnt = N/K
- Precondition, checked combinationally at accept: error if M==0 or P[2N-1:N] >= M.
  - On error: next state DONE, err=1, R=0. No RUN cycles.
- RUN, each edge:
  - Apply K reduce steps in sequence, MSB of lo first. Each step: t = 2*acc + lo[N-1]; lo <<= 1; acc = (t >= mod) ? t - mod : t.
  - Decrement cnt.
  - On the edge where cnt goes 1->0: state -> DONE, R <= acc[N-1:0], err <= 0.
- Invariant: acc < mod before every step, so t < 2*mod <= 2^(N+1). The N+1-bit datapath never overflows, and a single conditional subtract per step is sufficient.
- out_valid = (state==DONE), a registered-state decode, high for exactly one cycle.
- Latency, with the accept edge as edge 0:
  - Normal: out_valid is high in the cycle following edge N/K (sampled at edge N/K+1). N=256, K=1 gives 257; K=4 gives 65.
  - Error: sampled at edge 1.
  - in_ready returns to 1 in the cycle after DONE. Back-to-back issue interval is N/K+2 cycles.
- No output backpressure: the downstream stage must take R on the out_valid pulse. R and err remain stable until the next DONE.
- in_valid while in RUN or DONE: ignored, and no state is disturbed. P and M are sampled only at accept, so input changes after accept have no effect.
- Reset during RUN or DONE: abort immediately. No out_valid is produced, and the next transaction after release is fully correct.
- M==1: the result is R=0, err=0, with normal latency.

Decomposition:
- Package modred_pkg holds:
  - N default
  - state enum: IDLE, RUN, DONE
  - function lat(N,K) = N/K + 1
- Sub-module modred_step: combinational single shift-conditional-subtract.
  - Inputs: acc (N+1 bits), bit, mod (N bits).
  - Output: acc_next (N+1 bits).
  - modred_serial instantiates it K times in a chain.
- Top FSM, counter and registers: about 150–200 lines of RTL.

Test Plan:
- Directed 1, max operands: P=(2^256-1)^2, M=2^256-1, K=1 -> R=0, err=0. out_valid is exactly one pulse, sampled at edge 257.
- Directed 2, prime modulus: M=2^256-189, P=(M-1)^2 -> R=1, err=0. Repeat with K=4: same R, out_valid sampled at edge 65.
- Directed 3, small values: P=12345, M=1000 -> R=345. Then P=999, M=1000 -> R=999. Then M=1, P=7 -> R=0.
- Directed 4, error path:
  - M=0 -> err=1, R=0, out_valid sampled at edge 1.
  - P=2^511, M=5 -> err=1, R=0.
  - A following valid transaction clears err to 0.
- Directed 5, interference and reset:
  - Pulse in_valid with new P/M 10 cycles into RUN -> ignored; original result still correct.
  - Assert reset 100 cycles into RUN -> out_valid stays 0, state returns to IDLE.
  - After release, P=12345, M=1000 -> R=345.
- Random: 1000 back-to-back transactions with X,Y < M, P = X*Y taken from the fastKaratsuba output -> R matches the (X*Y)%M scoreboard every time. Issue interval is exactly N/K+2 cycles.

Source files
------------

// File: rtl/modred_pkg.sv
// Shared types and constants for the serial modular reducer.
package modred_pkg;

    localparam int N_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Edge (counting the accept edge as 0) at which a consumer samples out_valid.
    function automatic int lat(input int n, input int k);
        return n / k + 1;
    endfunction

endpackage

// File: rtl/modred_step.sv
// One radix-2 reduce step: shift in one product bit, then subtract the modulus if needed.
module modred_step #(
    parameter int N = 256
) (
    input  logic [N:0]   acc_i,
    input  logic         bit_i,
    input  logic [N-1:0] mod_i,
    output logic [N:0]   acc_next_o
);

    logic [N+1:0] t;
    logic [N:0]   diff;
    logic         ge;

    // acc < mod keeps t below 2*mod, so the difference always fits in N+1 bits
    // and one conditional subtract restores acc < mod.
    always_comb begin
        t          = {acc_i, bit_i};
        ge         = (t >= {2'b00, mod_i});
        diff       = t[N:0] - {1'b0, mod_i};
        acc_next_o = ge ? diff : t[N:0];
    end

endmodule

// File: rtl/modred_serial.sv
// Sequential reducer: R = P mod M, retiring K bits of the low product half per cycle.
// K must divide N and be one of 1, 2, 4, 8.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// RUN   | shifting lo into acc, K steps per cycle, cnt cycles left
// DONE  | R/err valid, out_valid pulse; returns to IDLE next edge
module modred_serial
    import modred_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] P,
    input  logic [N-1:0]   M,
    output logic [N-1:0]   R,
    output logic           out_valid,
    output logic           err
);

    localparam int ITER = N / K;
    localparam int CW   = $clog2(ITER + 1);

    state_e        state_q, state_d;
    logic [N:0]    acc_q, acc_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  mod_q, mod_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  r_q, r_d;
    logic          err_q, err_d;

    logic [K:0][N:0] acc_chain;
    logic            pre_err;

    assign acc_chain[0] = acc_q;

    genvar g;
    generate
        for (g = 0; g < K; g++) begin : g_step
            modred_step #(.N(N)) u_step (
                .acc_i      (acc_chain[g]),
                .bit_i      (lo_q[N-1-g]),
                .mod_i      (mod_q),
                .acc_next_o (acc_chain[g+1])
            );
        end
    endgenerate

    // A zero modulus or an upper half already >= M would break the acc < mod invariant.
    assign pre_err = (M == '0) || (P[2*N-1:N] >= M);

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            lo_q    <= '0;
            mod_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        mod_d   = mod_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = {1'b0, P[2*N-1:N]};
                    lo_d  = P[N-1:0];
                    mod_d = M;
                    cnt_d = CW'(ITER);
                    if (pre_err) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        r_d     = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_chain[K];
                lo_d  = lo_q << K;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    r_d     = acc_chain[K][N-1:0];
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign R         = r_q;
    assign err       = err_q;

endmodule
